// File: rtl/uart_rx_fifo_if.sv
// Bundles the receiver-side handshake and the host-side FWFT read port of uart_rx_fifo.
// The FIFO block uses the slave modport; a driver such as a bench or a host uses master.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rdy_clr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;
    logic          rx_timeout;

    modport slave (
        input  rx_rdy, rx_data, rd_en, ovf_clr,
        output rdy_clr, rd_data, empty, full, count, overflow, rx_timeout
    );

    modport master (
        output rx_rdy, rx_data, rd_en, ovf_clr,
        input  rdy_clr, rd_data, empty, full, count, overflow, rx_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures bytes from a level-held UART ready flag into a first-word-fall-through FIFO.
// Optional idle timeout flag is built when RXFIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 8680
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..256, TIMEOUT_CYC in 1..65535");
    end

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q;
    logic            rdy_clr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            empty_q;
    logic            full_q;
    logic            overflow_q;
    logic [7:0]      mem_q [DEPTH];

    logic            capture;
    logic            wr_en;
    logic            rd_ok;
    logic            drop;

    // A full FIFO still accepts a byte when the same-cycle pop frees a slot.
    always_comb begin
        capture = (state_q == IDLE) && bus.rx_rdy;
        wr_en   = capture && (!full_q || bus.rd_en);
        rd_ok   = bus.rd_en && !empty_q;
        drop    = capture && !wr_en;
        count_d = count_q;
        case ({wr_en, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_clr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.rx_rdy) begin
                    rdy_clr_q <= 1'b1;
                    state_q   <= ACK;
                end
                ACK: if (!bus.rx_rdy) begin
                    rdy_clr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    rdy_clr_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Memory is cleared on reset so the FWFT output reads zero before the first byte.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= bus.rx_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == (AW + 1)'(DEPTH));
            if (drop)             overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    assign bus.rdy_clr  = rdy_clr_q;
    assign bus.rd_data  = mem_q[rd_ptr_q];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef RXFIFO_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        timeout_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wr_en || empty_q)                 idle_q <= '0;
            else if (idle_q != 16'(TIMEOUT_CYC))  idle_q <= idle_q + 1'b1;
            timeout_q <= (idle_q == 16'(TIMEOUT_CYC)) && !empty_q;
        end
    end

    assign bus.rx_timeout = timeout_q;
`else
    assign bus.rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, default build): a vector table for the
// basic handshake and FWFT behaviour plus hand sequences for wrap, overflow and reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    uart_rx_fifo_if #(.DEPTH(16)) bus ();

    uart_rx_fifo #(.DEPTH(16), .TIMEOUT_CYC(100)) dut (
        .clk_50m (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       rx_rdy;
        logic [7:0] rx_data;
        logic       rd_en;
        logic       ovf_clr;
        logic       e_rdy_clr;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic [7:0] e_rd_data;
        logic       chk_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rd);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        bus.rd_en   = rd;
        tick();
        check("ack_high", 32'(bus.rdy_clr), 32'd1);
        bus.rx_rdy = 1'b0;
        bus.rd_en  = 1'b0;
        tick();
        check("ack_low", 32'(bus.rdy_clr), 32'd0);
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        check("pop_data", 32'(bus.rd_data), 32'(exp));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[7] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rdy_clr",  32'(bus.rdy_clr),    32'd0);
        check("rst_empty",    32'(bus.empty),      32'd1);
        check("rst_full",     32'(bus.full),       32'd0);
        check("rst_count",    32'(bus.count),      32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);
        check("rst_timeout",  32'(bus.rx_timeout), 32'd0);
        check("rst_rd_data",  32'(bus.rd_data),    32'd0);
        rst_n = 1'b1;
        tick();

        // Handshake and FWFT table
        for (int i = 0; i < 10; i++) begin
            bus.rx_rdy  = vecs[i].rx_rdy;
            bus.rx_data = vecs[i].rx_data;
            bus.rd_en   = vecs[i].rd_en;
            bus.ovf_clr = vecs[i].ovf_clr;
            tick();
            check($sformatf("v%0d_rdy_clr", i), 32'(bus.rdy_clr),  32'(vecs[i].e_rdy_clr));
            check($sformatf("v%0d_count", i),   32'(bus.count),    32'(vecs[i].e_count));
            check($sformatf("v%0d_empty", i),   32'(bus.empty),    32'(vecs[i].e_empty));
            check($sformatf("v%0d_full", i),    32'(bus.full),     32'(vecs[i].e_full));
            check($sformatf("v%0d_ovf", i),     32'(bus.overflow), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_timeout", i), 32'(bus.rx_timeout), 32'd0);
            if (vecs[i].chk_data)
                check($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(vecs[i].e_rd_data));
        end
        bus.rx_rdy  = 1'b0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;

        // Order and pointer wrap
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        check("wrap_count16", 32'(bus.count), 32'd16);
        check("wrap_full",    32'(bus.full),  32'd1);
        for (int i = 0; i < 16; i++) pop_byte(8'(i));
        check("wrap_empty1", 32'(bus.empty), 32'd1);
        for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b0);
        check("wrap_count8", 32'(bus.count), 32'd8);
        for (int i = 16; i < 24; i++) pop_byte(8'(i));
        check("wrap_empty2", 32'(bus.empty), 32'd1);
        check("wrap_count0", 32'(bus.count), 32'd0);

        // Overflow: 17th byte dropped, acknowledge still pulses
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        check("ovf_full_pre", 32'(bus.full),     32'd1);
        check("ovf_pre",      32'(bus.overflow), 32'd0);
        send_byte(8'h10, 1'b0);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd16);
        check("ovf_full",  32'(bus.full),     32'd1);
        tick();
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 32'd0);
        pop_byte(8'h00);
        check("ovf_count15", 32'(bus.count), 32'd15);

        // Full with a simultaneous pop accepts the new byte
        send_byte(8'hEE, 1'b0);
        check("fr_full", 32'(bus.full), 32'd1);
        check("fr_head", 32'(bus.rd_data), 32'h01);
        send_byte(8'h55, 1'b1);
        check("fr_count", 32'(bus.count),    32'd16);
        check("fr_full2", 32'(bus.full),     32'd1);
        check("fr_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 2; i < 16; i++) pop_byte(8'(i));
        pop_byte(8'hEE);
        pop_byte(8'h55);
        check("fr_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset in the middle of an acknowledge
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hC5;
        tick();
        check("ar_ack",    32'(bus.rdy_clr), 32'd1);
        check("ar_count5", 32'(bus.count),   32'd5);
        #3 rst_n = 1'b0;
        #1;
        check("ar_count0",  32'(bus.count),   32'd0);
        check("ar_empty",   32'(bus.empty),   32'd1);
        check("ar_rdy_clr", 32'(bus.rdy_clr), 32'd0);
        check("ar_full",    32'(bus.full),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_recap_count", 32'(bus.count),   32'd1);
        check("ar_recap_ack",   32'(bus.rdy_clr), 32'd1);
        check("ar_recap_data",  32'(bus.rd_data), 32'hC5);
        bus.rx_rdy = 1'b0;
        tick();
        check("ar_ack_low", 32'(bus.rdy_clr), 32'd0);
        pop_byte(8'hC5);
        check("ar_empty2", 32'(bus.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
